dice_traffic_sched: RTL and testbench

- Sequencer that owns the select line of the dice/traffic-light output multiplexer.
- Traffic lights are shown by default. A user request takes the display to the dice, runs a throw, holds the result on the display, then returns to traffic.
- Switches to the dice only while traffic shows red alone and after a minimum traffic dwell.
- Sits beside the dice, traffic and mux instances in the top level; drives mux sel and the dice button input.

---
 rtl/dice_traffic_sched_if.sv | 28 ++
 rtl/dice_traffic_sched.sv | 133 +++++++++++++
 tb/tb_dice_traffic_sched.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dice_traffic_sched_if.sv
// Handshake/bus bundle between the dice/traffic display sequencer and its
// surroundings.
//   req     : user throw request (level, rising edge is the event)
//   rag     : traffic light state {red, amber, green}
//   sel     : mux select, 1 = traffic, 0 = dice
//   roll    : dice button drive, 1 = dice rolling
//   busy    : request pending or being served
//   dropped : one-cycle pulse, a request edge was ignored
// master : drives req/rag, observes the sequencer outputs
// slave  : the sequencer itself
interface dice_traffic_sched_if;
  logic       req;
  logic [2:0] rag;
  logic       sel;
  logic       roll;
  logic       busy;
  logic       dropped;

  modport master (
    output req, rag,
    input  sel, roll, busy, dropped
  );

  modport slave (
    input  req, rag,
    output sel, roll, busy, dropped
  );
endinterface

// File: rtl/dice_traffic_sched.sv
// Sequencer owning the select line of the dice/traffic-light output mux.
// Traffic is shown by default; a user request switches the display to the
// dice (only while traffic shows red alone and after a minimum traffic
// dwell), holds the dice button for ROLL_CYCLES, shows the settled result
// for HOLD_CYCLES, then returns to traffic.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : dice_traffic_sched_if.slave (req, rag in; sel, roll, busy, dropped out)
// All outputs are registered; there is no input-to-output combinational path.
module dice_traffic_sched #(
  parameter int unsigned MIN_TRAFFIC = 6,
  parameter int unsigned ROLL_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dice_traffic_sched_if.slave   bus
);

  localparam int unsigned DW   = $clog2(MIN_TRAFFIC + 1);
  localparam int unsigned PMAX = (ROLL_CYCLES > HOLD_CYCLES) ? ROLL_CYCLES : HOLD_CYCLES;
  localparam int unsigned PW   = $clog2(PMAX + 1);

  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_TRAFFIC);
  localparam logic [PW-1:0] ROLL_LOAD = PW'(ROLL_CYCLES - 1);
  localparam logic [PW-1:0] HOLD_LOAD = PW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    TRAFFIC = 2'd0,
    WAIT    = 2'd1,
    ROLL    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          req_q, req_d;
  logic          armed_q, armed_d;
  logic          sel_q, sel_d;
  logic          roll_q, roll_d;
  logic          busy_q, busy_d;
  logic          dropped_q, dropped_d;
  logic          req_edge;

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    phase_d   = phase_q;
    dropped_d = 1'b0;
    req_d     = bus.req;
    armed_d   = 1'b1;
    // req_q is cleared by reset, so a req held high through reset would look
    // like a fresh edge on the first clock; armed_q masks that one edge.
    req_edge  = bus.req & ~req_q & armed_q;

    unique case (state_q)
      TRAFFIC: begin
        if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 1'b1;
        if (req_edge) state_d = WAIT;
      end
      WAIT: begin
        if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 1'b1;
        dropped_d = req_edge;
        // Only red alone permits the switch; red+amber and illegal codes do not.
        if (bus.rag == 3'b100 && dwell_q == DWELL_MAX) begin
          state_d = ROLL;
          phase_d = ROLL_LOAD;
        end
      end
      ROLL: begin
        dropped_d = req_edge;
        if (phase_q == '0) begin
          state_d = SHOW;
          phase_d = HOLD_LOAD;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      SHOW: begin
        dropped_d = req_edge;
        if (phase_q == '0) begin
          state_d = TRAFFIC;
          dwell_d = '0;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      default: begin
        state_d = TRAFFIC;
        dwell_d = '0;
        phase_d = '0;
      end
    endcase

    // Outputs decoded from the next state so they change on the same edge
    // as the state; sel and roll can never be high together.
    sel_d  = (state_d == TRAFFIC) || (state_d == WAIT);
    roll_d = (state_d == ROLL);
    busy_d = (state_d != TRAFFIC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= TRAFFIC;
      dwell_q   <= '0;
      phase_q   <= '0;
      req_q     <= 1'b0;
      armed_q   <= 1'b0;
      sel_q     <= 1'b1;
      roll_q    <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      phase_q   <= phase_d;
      req_q     <= req_d;
      armed_q   <= armed_d;
      sel_q     <= sel_d;
      roll_q    <= roll_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.roll    = roll_q;
  assign bus.busy    = busy_q;
  assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_dice_traffic_sched.sv
// Bench for dice_traffic_sched: table-driven nominal/drop sequence, hand
// sequences for reset, red gating, dwell gating and mid-throw reset, and a
// randomized run, all checked against a timestamp-based reference model.
module tb_dice_traffic_sched;
  localparam int MIN_T  = 6;
  localparam int ROLL_C = 4;
  localparam int HOLD_C = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dice_traffic_sched_if dif();

  dice_traffic_sched #(
    .MIN_TRAFFIC(MIN_T),
    .ROLL_CYCLES(ROLL_C),
    .HOLD_CYCLES(HOLD_C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: throws are described by the edge index at which the dice
  // took over (r_start); everything else follows from elapsed edge counts.
  int cyc = 0;
  int t_entry;       // edge index at which traffic mode was (re)entered
  int r_start;
  bit r_valid;
  bit waiting;
  bit prev_req;
  bit armed;
  bit m_sel, m_roll, m_busy, m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    waiting  = 0;
    r_valid  = 0;
    r_start  = 0;
    prev_req = 0;
    armed    = 0;
    t_entry  = cyc;
    m_sel = 1; m_roll = 0; m_busy = 0; m_drop = 0;
  endtask

  task automatic model_edge(input bit rq, input logic [2:0] rg);
    int e, dwell, k;
    bit ev, in_dice, dice;
    e     = cyc;
    ev    = rq && !prev_req && armed;
    dwell = e - 1 - t_entry;
    if (dwell > MIN_T) dwell = MIN_T;
    k       = e - 1 - r_start;
    in_dice = r_valid && k >= 0 && k < ROLL_C + HOLD_C;
    m_drop  = 0;
    if (in_dice) begin
      m_drop = ev;
      if (e - r_start == ROLL_C + HOLD_C) t_entry = e;
    end else if (waiting) begin
      m_drop = ev;
      if (rg == 3'b100 && dwell == MIN_T) begin
        r_start = e;
        r_valid = 1;
        waiting = 0;
      end
    end else if (ev) begin
      waiting = 1;
    end
    prev_req = rq;
    armed    = 1;
    k      = e - r_start;
    dice   = r_valid && k >= 0 && k < ROLL_C + HOLD_C;
    m_roll = r_valid && k >= 0 && k < ROLL_C;
    m_sel  = !dice;
    m_busy = dice || waiting;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".sel"},     dif.sel,     m_sel);
    check({tag, ".roll"},    dif.roll,    m_roll);
    check({tag, ".busy"},    dif.busy,    m_busy);
    check({tag, ".dropped"}, dif.dropped, m_drop);
  endtask

  task automatic step(input bit rq, input logic [2:0] rg, input string tag);
    @(negedge clk);
    dif.req = rq;
    dif.rag = rg;
    @(posedge clk);
    cyc++;
    model_edge(rq, rg);
    #1;
    check_outputs(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".sel"},     dif.sel,     1'b1);
    check({tag, ".roll"},    dif.roll,    1'b0);
    check({tag, ".busy"},    dif.busy,    1'b0);
    check({tag, ".dropped"}, dif.dropped, 1'b0);
  endtask

  task automatic do_reset(input bit rq, input int n);
    @(negedge clk);
    dif.req = rq;
    rst = 1'b0;
    #1;
    check_reset_vals("rst_async");
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      check_reset_vals("rst_hold");
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Step until the model reports the display back on traffic (bounded).
  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((m_busy || !m_sel) && guard < 40) begin
      step(1'b0, 3'b100, tag);
      guard++;
    end
    check({tag, ".drain_bound"}, (guard < 40), 1'b1);
  endtask

  typedef struct {
    bit         req;
    logic [2:0] rag;
    bit         sel;
    bit         roll;
    bit         busy;
    bit         dropped;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_back, t_roll, guard, n_roll, n_show;
    bit got_roll;
    logic [2:0] rg;
    bit rq;

    // Nominal throw with drops in ROLL, SHOW and on the final SHOW edge.
    // Entry i is the state after request-relative edge N+i.
    vecs[0]  = '{1, 3'b100, 1, 0, 1, 0};
    vecs[1]  = '{0, 3'b100, 0, 1, 1, 0};
    vecs[2]  = '{1, 3'b100, 0, 1, 1, 1};
    vecs[3]  = '{0, 3'b100, 0, 1, 1, 0};
    vecs[4]  = '{0, 3'b100, 0, 1, 1, 0};
    vecs[5]  = '{0, 3'b001, 0, 0, 1, 0};
    vecs[6]  = '{1, 3'b010, 0, 0, 1, 1};
    vecs[7]  = '{0, 3'b100, 0, 0, 1, 0};
    vecs[8]  = '{0, 3'b100, 0, 0, 1, 0};
    vecs[9]  = '{0, 3'b100, 0, 0, 1, 0};
    vecs[10] = '{0, 3'b100, 0, 0, 1, 0};
    vecs[11] = '{0, 3'b100, 0, 0, 1, 0};
    vecs[12] = '{0, 3'b100, 0, 0, 1, 0};
    vecs[13] = '{1, 3'b100, 1, 0, 0, 1};
    vecs[14] = '{0, 3'b100, 1, 0, 0, 0};
    vecs[15] = '{0, 3'b100, 1, 0, 0, 0};

    dif.req = 1'b1;
    dif.rag = 3'b100;

    // Reset with req held high; release must not create a request event.
    do_reset(1'b1, 3);
    for (int i = 0; i < 10; i++) step(1'b1, 3'b100, "post_rst");

    // Table-driven nominal sequence.
    step(1'b0, 3'b100, "pre_tab");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      dif.req = vecs[i].req;
      dif.rag = vecs[i].rag;
      @(posedge clk);
      cyc++;
      model_edge(vecs[i].req, vecs[i].rag);
      #1;
      check($sformatf("tab%0d.sel", i),     dif.sel,     vecs[i].sel);
      check($sformatf("tab%0d.roll", i),    dif.roll,    vecs[i].roll);
      check($sformatf("tab%0d.busy", i),    dif.busy,    vecs[i].busy);
      check($sformatf("tab%0d.dropped", i), dif.dropped, vecs[i].dropped);
      check_outputs($sformatf("tab%0d.model", i));
    end

    // Red gating: request while green, red+amber must not switch, drop in WAIT.
    for (int i = 0; i < 8; i++) step(1'b0, 3'b001, "red_pre");
    step(1'b1, 3'b001, "red_req");
    check("red_req.busy", dif.busy, 1'b1);
    step(1'b0, 3'b001, "red_wait");
    step(1'b1, 3'b110, "red_wait_drop");
    check("red_wait_drop.dropped", dif.dropped, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'b110, "red_amber");
      check("red_amber.sel", dif.sel, 1'b1);
    end
    step(1'b0, 3'b100, "red_go");
    check("red_go.sel", dif.sel, 1'b0);
    drain("red_drain");
    t_back = cyc;

    // Dwell gating: request 2 edges after returning to traffic.
    step(1'b0, 3'b100, "dwell_a");
    step(1'b1, 3'b100, "dwell_req");
    guard = 0;
    got_roll = 0;
    t_roll = 0;
    while (!got_roll && guard < 30) begin
      step(1'b0, 3'b100, "dwell_wait");
      if (dif.roll === 1'b1) begin
        got_roll = 1;
        t_roll = cyc;
      end
      guard++;
    end
    check("dwell.roll_seen", got_roll, 1'b1);
    check("dwell.gap", t_roll - t_back, MIN_T + 1);
    drain("dwell_drain");

    // Reset asserted during the second ROLL cycle.
    for (int i = 0; i < 8; i++) step(1'b0, 3'b100, "mr_idle");
    step(1'b1, 3'b100, "mr_req");
    step(1'b0, 3'b100, "mr_roll1");
    step(1'b0, 3'b100, "mr_roll2");
    check("mr_roll2.roll", dif.roll, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("mr_async.roll", dif.roll, 1'b0);
    check("mr_async.sel",  dif.sel,  1'b1);
    check("mr_async.busy", dif.busy, 1'b0);
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 3'b100, "mr_post");
    step(1'b1, 3'b100, "mr_req2");
    n_roll = 0;
    n_show = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 3'b100, "mr_seq");
      if (dif.roll === 1'b1) n_roll++;
      if (dif.sel === 1'b0 && dif.roll === 1'b0) n_show++;
    end
    check("mr_seq.roll_cycles", n_roll, ROLL_C);
    check("mr_seq.show_cycles", n_show, HOLD_C);

    // Randomized run against the model.
    rq = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) rq = ~rq;
      case ($urandom_range(0, 5))
        0, 1, 2: rg = 3'b100;
        3:       rg = 3'b110;
        4:       rg = 3'b001;
        default: rg = 3'($urandom_range(0, 7));
      endcase
      step(rq, rg, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
